// File: rtl/fp_pkg.sv
// Shared FP multiplier definitions: operand classes, flag bit positions, bias and classification helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    KIND_NORM = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_INF  = 2'd2,
    KIND_NAN  = 2'd3
  } kind_t;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Subnormal encodings (exp==0, frac!=0) deliberately classify as zero.
  function automatic kind_t classify(input logic exp_ones, input logic exp_zero, input logic frac_nz);
    if (exp_ones) return frac_nz ? KIND_NAN : KIND_INF;
    if (exp_zero) return KIND_ZERO;
    return KIND_NORM;
  endfunction

  function automatic kind_t combine_kind(input kind_t ka, input kind_t kb);
    if (ka == KIND_NAN || kb == KIND_NAN) return KIND_NAN;
    if ((ka == KIND_INF && kb == KIND_ZERO) || (ka == KIND_ZERO && kb == KIND_INF)) return KIND_NAN;
    if (ka == KIND_INF || kb == KIND_INF) return KIND_INF;
    if (ka == KIND_ZERO || kb == KIND_ZERO) return KIND_ZERO;
    return KIND_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational back end of the multiplier: normalise, round-to-nearest-even, overflow/FTZ, specials, pack.
module fp_mul_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp,
  input  kind_t                    kind,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAG_W-1:0]        flags
);

  localparam int PROD_W  = 2 * MAN_W + 2;
  localparam int EW2     = EXP_W + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W+MAN_W:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W+MAN_W-1:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic                   msb;
  logic [PROD_W-1:0]      norm;
  logic signed [EW2-1:0]  exp_n;
  logic [MAN_W-1:0]       frac;
  logic                   guard_bit;
  logic                   round_bit;
  logic                   sticky_bit;
  logic                   rnd_up;
  logic [MAN_W+1:0]       sig_r;
  logic                   carry;
  logic [MAN_W-1:0]       frac_r;
  logic signed [EW2-1:0]  exp_r;
  logic                   ovf;
  logic                   unf;
  logic                   inexact;

  // Product of two [1,2) significands lies in [1,4); left-align the leading one.
  assign msb        = prod[PROD_W-1];
  assign norm       = msb ? prod : (prod << 1);
  assign exp_n      = exp + EW2'(msb);
  assign frac       = norm[PROD_W-2 -: MAN_W];
  assign guard_bit  = norm[MAN_W];
  assign round_bit  = norm[MAN_W-1];
  assign sticky_bit = |norm[MAN_W-2:0];
  assign rnd_up     = guard_bit & (round_bit | sticky_bit | frac[0]);
  assign sig_r      = {1'b0, 1'b1, frac} + (MAN_W+2)'(rnd_up);
  assign carry      = sig_r[MAN_W+1];
  assign frac_r     = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
  assign exp_r      = exp_n + EW2'(carry);
  assign ovf        = !exp_r[EW2-1] && ($unsigned(exp_r) >= EW2'(EXP_MAX));
  assign unf        = exp_r[EW2-1] || (exp_r == '0);
  assign inexact    = guard_bit | round_bit | sticky_bit;

  always_comb begin
    result = '0;
    flags  = '0;
    case (kind)
      KIND_NAN: begin
        result              = QNAN;
        flags[FLAG_INVALID] = 1'b1;
      end
      KIND_INF:  result = {sign, INF_MAG};
      KIND_ZERO: result = {sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (ovf) begin
          result               = {sign, INF_MAG};
          flags[FLAG_OVERFLOW] = 1'b1;
          flags[FLAG_INEXACT]  = 1'b1;
        end else if (unf) begin
          result                = {sign, {(EXP_W+MAN_W){1'b0}}};
          flags[FLAG_UNDERFLOW] = 1'b1;
          flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          result              = {sign, exp_r[EXP_W-1:0], frac_r};
          flags[FLAG_INEXACT] = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (unpack / significand product / round+pack), 3-cycle latency,
// one op per cycle; a stalled output (out_valid && !out_ready) freezes every stage and drops in_ready.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [FLAG_W-1:0]    flags
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EW2    = EXP_W + 2;
  localparam int BIAS   = bias_of(EXP_W);

  logic en;
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  kind_t            ka, kb;

  assign ea = a[MAN_W +: EXP_W];
  assign eb = b[MAN_W +: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign ka = classify(&ea, ~|ea, |fa);
  assign kb = classify(&eb, ~|eb, |fb);

  logic                  s1_valid, s1_sign;
  logic signed [EW2-1:0] s1_exp;
  kind_t                 s1_kind;
  logic [SIG_W-1:0]      s1_sig_a, s1_sig_b;

  logic                  s2_valid, s2_sign;
  logic signed [EW2-1:0] s2_exp;
  kind_t                 s2_kind;
  logic [PROD_W-1:0]     s2_prod;

  logic [EXP_W+MAN_W:0]  rnd_result;
  logic [FLAG_W-1:0]     rnd_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      result    <= rnd_result;
      flags     <= rnd_flags;
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign  <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      s1_exp   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - EW2'(BIAS);
      s1_kind  <= combine_kind(ka, kb);
      s1_sig_a <= {1'b1, fa};
      s1_sig_b <= {1'b1, fb};

      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_kind  <= s1_kind;
      s2_prod  <= s1_sig_a * s1_sig_b;
    end
  end

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign   (s2_sign),
    .exp    (s2_exp),
    .kind   (s2_kind),
    .prod   (s2_prod),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: FP32 and FP16 instances, arithmetic, specials, backpressure and reset flush.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  fl32;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  fl16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .result    (res32),
    .flags     (fl32)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .result    (res16),
    .flags     (fl16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated operation: checks acceptance, 3-cycle latency, result and flags.
  task automatic do_op(input bit f16, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_fl, input string tag);
    int n;
    @(negedge clk);
    if (f16) begin
      in_valid16 = 1'b1; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      in_valid32 = 1'b1; a32 = a; b32 = b;
    end
    #1;
    chk({tag, "_in_ready"}, f16 ? in_ready16 : in_ready32, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    n = 1;
    while (!(f16 ? out_valid16 : out_valid32) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    if (f16) begin
      chk({tag, "_result"}, res16, exp_res[15:0]);
      chk({tag, "_flags"}, fl16, exp_fl);
    end else begin
      chk({tag, "_result"}, res32, exp_res);
      chk({tag, "_flags"}, fl32, exp_fl);
    end
  endtask

  // Stream operand i is (1 + i*2^-5) * 2^i; times 2.0 only bumps the exponent.
  function automatic logic [31:0] stream_a(input int i);
    return {1'b0, 8'(127 + i), 23'(i << 18)};
  endfunction

  function automatic logic [31:0] stream_exp(input int i);
    return {1'b0, 8'(128 + i), 23'(i << 18)};
  endfunction

  initial begin
    int sent;
    int recv;
    int stale;
    logic [31:0] held;

    reset = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid32", out_valid32, 0);
    chk("rst_in_ready32", in_ready32, 1);
    chk("rst_result32", res32, 0);
    chk("rst_flags32", fl32, 0);
    chk("rst_out_valid16", out_valid16, 0);

    do_op(1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul_1p5x2");
    do_op(1'b0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, "mul_m2x3");
    do_op(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rne");
    do_op(1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_zero");
    do_op(1'b0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, "overflow");
    do_op(1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, "underflow");
    do_op(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "neg_inf");
    do_op(1'b1, 32'h00003C00, 32'h00004000, 32'h00004000, 4'b0000, "h_1x2");
    do_op(1'b1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101, "h_overflow");

    // Streaming with a 5-cycle consumer stall in the middle.
    sent = 0;
    recv = 0;
    held = '0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      @(negedge clk);
      out_ready32 = !(c >= 6 && c < 11);
      in_valid32  = (sent < 8);
      a32         = stream_a(sent);
      b32         = 32'h40000000;
      #1;
      if (c == 6) held = res32;
      if (c == 10) begin
        chk("bp_in_ready", in_ready32, 0);
        chk("bp_out_valid", out_valid32, 1);
        chk("bp_hold", res32, held);
      end
      if (in_valid32 && in_ready32) sent++;
      if (out_valid32 && out_ready32) begin
        chk($sformatf("bp_res%0d", recv), res32, stream_exp(recv));
        recv++;
      end
    end
    @(negedge clk);
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    chk("bp_recv_count", recv, 8);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid32) stale++;
    end
    chk("bp_no_dup", stale, 0);

    // Fill the pipe with three ops behind a stalled output, then reset.
    out_ready32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid32 = 1'b1;
      a32 = 32'h3FC00000;
      b32 = 32'h40000000;
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    chk("rst_mid_full", out_valid32, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_out_valid", out_valid32, 0);
    out_ready32 = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid32) stale++;
    end
    chk("rst_mid_no_stale", stale, 0);
    chk("rst_mid_in_ready", in_ready32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
